// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// register-file write-port arbiter.
package rf_wr_arbiter_pkg;

   localparam int CONFLICT_CNT_WIDTH = 16;
   localparam int MAX_REQ            = 4;
   localparam int RF_ADDR_W          = 5;
   localparam int RF_DATA_W          = 32;

   // One register-file write; the staged entry is held in this form.
   // The top-level width parameters default to these field widths.
   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] data;
   } wr_req_t;

   // One-hot pick of the first valid requester, searching from ptr and
   // wrapping modulo n. All-zero when nothing is valid.
   function automatic logic [MAX_REQ-1:0] rr_pick_f(
      input logic [MAX_REQ-1:0] valid,
      input logic [1:0]         ptr,
      input int                 n
   );
      logic [MAX_REQ-1:0] g;
      logic               found;
      logic [1:0]         idx;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n && !found) begin
            idx = 2'((int'(ptr) + k) % n);
            if (valid[idx]) begin
               g[idx] = 1'b1;
               found  = 1'b1;
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant generator: round-robin from a held pointer, or lowest-index-wins
// when fixed priority is selected. Grant is forced to zero during reset.
module rr_arbiter
   import rf_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               fixed_prio_i,
   input  logic [NUM_REQ-1:0] valid_i,
   output logic [NUM_REQ-1:0] grant_o
);

   localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [MAX_REQ-1:0] pick;
   logic [1:0]         start;
   logic               unused_pick;

   // Search start depends on mode; the pointer itself is never touched here.
   always_comb begin
      start   = fixed_prio_i ? 2'd0 : 2'(ptr_q);
      pick    = rr_pick_f(MAX_REQ'(valid_i), start, NUM_REQ);
      grant_o = arst ? '0 : pick[NUM_REQ-1:0];
   end

   assign unused_pick = ^pick;

   // Pointer moves past the winner only in round-robin mode.
   always_comb begin
      ptr_d = ptr_q;
      if (!fixed_prio_i) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_o[i]) ptr_d = PTR_W'((i + 1) % NUM_REQ);
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: grants one producer per cycle, stages
// the winner for one cycle onto the rf write port, offers a bypass compare
// against the staged write and counts contended cycles.
module rf_wr_arbiter
   import rf_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_W,
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = RF_ADDR_W
) (
   input  logic                            clk,
   input  logic                            arst,
   input  logic                            fixed_prio_in,
   input  logic [NUM_REQ-1:0]              req_valid_in,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_rd_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_in,
   output logic [NUM_REQ-1:0]              req_ready_out,
   output logic                            wb_en_out,
   output logic [ADDR_WIDTH-1:0]           wb_rd_out,
   output logic [DATA_WIDTH-1:0]           wb_data_out,
   input  logic [ADDR_WIDTH-1:0]           byp_rs1_in,
   input  logic [ADDR_WIDTH-1:0]           byp_rs2_in,
   output logic                            byp_rs1_hit_out,
   output logic                            byp_rs2_hit_out,
   output logic [DATA_WIDTH-1:0]           byp_data_out,
   output logic [CONFLICT_CNT_WIDTH-1:0]   conflict_cnt_out
);

   logic [NUM_REQ-1:0]            grant;
   logic                          accept;
   wr_req_t                       sel;
   wr_req_t                       stage_q, stage_d;
   logic                          wb_en_q, wb_en_d;
   logic [2:0]                    nvalid;
   logic [CONFLICT_CNT_WIDTH-1:0] cnt_q, cnt_d;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk          (clk),
      .arst         (arst),
      .fixed_prio_i (fixed_prio_in),
      .valid_i      (req_valid_in),
      .grant_o      (grant)
   );

   // The write stage never stalls, so ready is simply the grant.
   assign req_ready_out = grant;

   // Mux the granted requester's rd/data; grant is one-hot or zero.
   always_comb begin
      sel    = '0;
      accept = |grant;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel.rd   = RF_ADDR_W'(req_rd_in[i*ADDR_WIDTH +: ADDR_WIDTH]);
            sel.data = RF_DATA_W'(req_data_in[i*DATA_WIDTH +: DATA_WIDTH]);
         end
      end
   end

   // An accepted rd=0 write still loads the stage but never raises the
   // enable, so x0 is never written and never hits the bypass.
   always_comb begin
      wb_en_d = accept && (sel.rd != '0);
      stage_d = accept ? sel : stage_q;
   end

   // Write stage; reset drops whatever was staged.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wb_en_q <= 1'b0;
         stage_q <= '0;
      end else begin
         wb_en_q <= wb_en_d;
         stage_q <= stage_d;
      end
   end

   assign wb_en_out    = wb_en_q;
   assign wb_rd_out    = ADDR_WIDTH'(stage_q.rd);
   assign wb_data_out  = DATA_WIDTH'(stage_q.data);
   assign byp_data_out = wb_data_out;

   assign byp_rs1_hit_out = wb_en_q && (wb_rd_out == byp_rs1_in) && (byp_rs1_in != '0);
   assign byp_rs2_hit_out = wb_en_q && (wb_rd_out == byp_rs2_in) && (byp_rs2_in != '0);

   // Saturating count of cycles with two or more valid requesters.
   always_comb begin
      nvalid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid_in[i]) nvalid = nvalid + 3'd1;
      end
      cnt_d = cnt_q;
      if (nvalid >= 3'd2 && cnt_q != '1) cnt_d = cnt_q + CONFLICT_CNT_WIDTH'(1);
   end

   // Conflict counter register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign conflict_cnt_out = cnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter with a behavioural reference model
// checked every cycle plus hand-computed literal expectations.
module tb_rf_wr_arbiter;

   localparam int NR = 2;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            arst = 1'b1;
   logic            fixed_prio_in = 1'b0;
   logic [NR-1:0]   req_valid_in = '0;
   logic [NR*AW-1:0] req_rd_in = '0;
   logic [NR*DW-1:0] req_data_in = '0;
   logic [NR-1:0]   req_ready_out;
   logic            wb_en_out;
   logic [AW-1:0]   wb_rd_out;
   logic [DW-1:0]   wb_data_out;
   logic [AW-1:0]   byp_rs1_in = '0;
   logic [AW-1:0]   byp_rs2_in = '0;
   logic            byp_rs1_hit_out, byp_rs2_hit_out;
   logic [DW-1:0]   byp_data_out;
   logic [15:0]     conflict_cnt_out;

   int total = 0;
   int bad   = 0;

   rf_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .arst(arst), .fixed_prio_in(fixed_prio_in),
      .req_valid_in(req_valid_in), .req_rd_in(req_rd_in), .req_data_in(req_data_in),
      .req_ready_out(req_ready_out), .wb_en_out(wb_en_out), .wb_rd_out(wb_rd_out),
      .wb_data_out(wb_data_out), .byp_rs1_in(byp_rs1_in), .byp_rs2_in(byp_rs2_in),
      .byp_rs1_hit_out(byp_rs1_hit_out), .byp_rs2_hit_out(byp_rs2_hit_out),
      .byp_data_out(byp_data_out), .conflict_cnt_out(conflict_cnt_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_p   = 0;
   bit          m_en  = 0;
   logic [AW-1:0] m_rd  = '0;
   logic [DW-1:0] m_data = '0;
   int          m_cnt = 0;

   // Winner index: first valid requester scanning from the start point.
   function automatic int winner(input logic [NR-1:0] v, input int p, input bit fx);
      int s;
      s = fx ? 0 : p;
      for (int k = 0; k < NR; k++)
         if (v[(s + k) % NR]) return (s + k) % NR;
      return -1;
   endfunction

   function automatic logic [NR-1:0] exp_ready();
      int g;
      g = winner(req_valid_in, m_p, fixed_prio_in);
      if (arst || g < 0) return '0;
      return NR'(1) << g;
   endfunction

   always @(posedge clk or posedge arst) begin
      if (arst) begin
         m_p <= 0; m_en <= 0; m_rd <= '0; m_data <= '0; m_cnt <= 0;
      end else begin : upd
         automatic int g = winner(req_valid_in, m_p, fixed_prio_in);
         if ($countones(req_valid_in) >= 2 && m_cnt < 65535) m_cnt <= m_cnt + 1;
         if (g >= 0) begin
            m_rd   <= req_rd_in[g*AW +: AW];
            m_data <= req_data_in[g*DW +: DW];
            m_en   <= (req_rd_in[g*AW +: AW] != 0);
            if (!fixed_prio_in) m_p <= (g + 1) % NR;
         end else begin
            m_en <= 0;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("m_ready", req_ready_out, exp_ready());
      chk("m_wb_en", wb_en_out, m_en);
      chk("m_wb_rd", wb_rd_out, m_rd);
      chk("m_wb_data", wb_data_out, m_data);
      chk("m_cnt", conflict_cnt_out, m_cnt);
      chk("m_hit1", byp_rs1_hit_out, m_en && m_rd == byp_rs1_in && byp_rs1_in != 0);
      chk("m_hit2", byp_rs2_hit_out, m_en && m_rd == byp_rs2_in && byp_rs2_in != 0);
      chk("m_byp_data", byp_data_out, m_data);
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int i, input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
      req_valid_in[i]            = v;
      req_rd_in[i*AW +: AW]      = rd;
      req_data_in[i*DW +: DW]    = d;
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [NR-1:0] rr_rdy [4];
      logic [AW-1:0] rr_rd  [4];
      rr_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
      rr_rd  = '{5'd1, 5'd2, 5'd1, 5'd2};

      // Reset state
      repeat (2) step();
      chk("rst_wb_en", wb_en_out, 0);
      chk("rst_cnt", conflict_cnt_out, 0);
      chk("rst_ready", req_ready_out, 0);
      arst = 1'b0;

      // Round-robin, both valid for 4 cycles
      set_req(0, 1, 5'd1, 32'hAAAA);
      set_req(1, 1, 5'd2, 32'hBBBB);
      #1;
      for (int c = 0; c < 4; c++) begin
         chk("rr_ready", req_ready_out, rr_rdy[c]);
         step();
         chk("rr_wb_rd", wb_rd_out, rr_rd[c]);
      end
      chk("rr_cnt", conflict_cnt_out, 4);

      // Single requester 1
      set_req(0, 0, 5'd0, 32'h0);
      set_req(1, 1, 5'd5, 32'hDEADBEEF);
      #1;
      chk("single_ready", req_ready_out, 2'b10);
      step();
      chk("single_en", wb_en_out, 1);
      chk("single_rd", wb_rd_out, 5);
      chk("single_data", wb_data_out, 32'hDEADBEEF);

      // x0 write: accepted but never enabled
      set_req(1, 0, 5'd0, 32'h0);
      set_req(0, 1, 5'd0, 32'h77);
      byp_rs1_in = 5'd0;
      #1;
      chk("x0_ready", req_ready_out, 2'b01);
      step();
      chk("x0_en", wb_en_out, 0);
      chk("x0_hit1", byp_rs1_hit_out, 0);

      // Fixed priority, pointer left at 1
      fixed_prio_in = 1'b1;
      set_req(0, 1, 5'd1, 32'h11);
      set_req(1, 1, 5'd2, 32'h22);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("fix_ready", req_ready_out, 2'b01);
         step();
      end
      chk("fix_cnt", conflict_cnt_out, 7);
      fixed_prio_in = 1'b0;
      #1;
      chk("resume_ready", req_ready_out, 2'b10);
      step();
      chk("resume_rd", wb_rd_out, 2);

      // Bypass
      set_req(1, 0, 5'd0, 32'h0);
      set_req(0, 1, 5'd7, 32'h1234);
      step();
      set_req(0, 0, 5'd0, 32'h0);
      byp_rs1_in = 5'd7;
      byp_rs2_in = 5'd8;
      #1;
      chk("byp_hit1", byp_rs1_hit_out, 1);
      chk("byp_hit2", byp_rs2_hit_out, 0);
      chk("byp_data", byp_data_out, 32'h1234);

      // Reset mid-cycle with a write staged
      set_req(0, 1, 5'd9, 32'h55);
      step();
      chk("pre_rst_en", wb_en_out, 1);
      set_req(0, 0, 5'd0, 32'h0);
      #2 arst = 1'b1;
      set_req(0, 1, 5'd3, 32'h33);
      set_req(1, 1, 5'd4, 32'h44);
      #1;
      chk("mid_rst_en", wb_en_out, 0);
      chk("mid_rst_rd", wb_rd_out, 0);
      chk("mid_rst_data", wb_data_out, 0);
      chk("mid_rst_cnt", conflict_cnt_out, 0);
      chk("mid_rst_ready", req_ready_out, 0);
      step();
      arst = 1'b0;
      #1;
      chk("post_rst_ready", req_ready_out, 2'b01);

      // Saturation of the conflict counter
      repeat (65540) step();
      chk("sat_cnt", conflict_cnt_out, 16'hFFFF);

      req_valid_in = '0;
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
